// File: rtl/spi_regfile_slave_if.sv
// SPI pin bundle between an AVR host (master) and the FPGA register file (slave).
interface spi_regfile_slave_if;
  logic spics_n;
  logic spick;
  logic spido;
  logic spidi;

  modport master (output spics_n, output spick, output spido, input spidi);
  modport slave  (input spics_n, input spick, input spido, output spidi);
endinterface

// File: rtl/spi_regfile_slave.sv
// SPI slave exposing NREGS registers of REGW bits to an AVR host.
// Frame: 8-bit command (bit7 write, bits3:0 index) then REGW data bits.
module spi_regfile_slave #(
  parameter int unsigned NREGS       = 4,
  parameter int unsigned REGW        = 16,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned LSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    fclk,
  input  logic                    rst,
  spi_regfile_slave_if.slave      spi,
  input  logic [7:0]              status_in,
  input  logic [NREGS*REGW-1:0]   rd_in,
  output logic [NREGS*REGW-1:0]   reg_out,
  output logic [NREGS-1:0]        wr_stb,
  output logic [NREGS-1:0]        rd_stb,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, OVR, LOCK} state_e;

  localparam logic [6:0] LAST_DBIT = 7'(REGW - 1);
  localparam logic [6:0] SYNC_CNT  = 7'(SYNC_STAGES);
  localparam logic       SCK_IDLE  = 1'(CPOL);

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sdo_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s, sdo_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;

  state_e                 state_q;
  logic [6:0]             cnt_q;
  logic [7:0]             cmd_q, cmd_nx;
  logic [REGW-1:0]        wbuf_q, wbuf_nx;
  logic [REGW-1:0]        obuf_q, stat_w, rd_sel;
  logic                   spidi_q;
  logic [NREGS*REGW-1:0]  reg_q;
  logic [NREGS-1:0]       wr_stb_q, rd_stb_q;
  logic                   err_q;
  logic                   idx_ok, idx_ok_nx;

  function automatic logic pick(input logic [REGW-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[REGW-1];
  endfunction

  function automatic logic [REGW-1:0] shift(input logic [REGW-1:0] v);
    return (LSB_FIRST != 0) ? {1'b0, v[REGW-1:1]} : {v[REGW-2:0], 1'b0};
  endfunction

  always_ff @(posedge fclk) begin
    if (rst) begin
      cs_sync_q  <= '1;
      sck_sync_q <= {SYNC_STAGES{SCK_IDLE}};
      sdo_sync_q <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi.spics_n};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi.spick};
      sdo_sync_q <= {sdo_sync_q[SYNC_STAGES-2:0], spi.spido};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  always_comb begin
    cs_s     = cs_sync_q[SYNC_STAGES-1];
    sck_s    = sck_sync_q[SYNC_STAGES-1] ^ SCK_IDLE;
    sdo_s    = sdo_sync_q[SYNC_STAGES-1];
    cs_fall  = cs_prev_q & ~cs_s;
    cs_rise  = ~cs_prev_q & cs_s;
    sck_rise = ~sck_prev_q & sck_s;
    sck_fall = sck_prev_q & ~sck_s;
  end

  always_comb begin
    cmd_nx  = (LSB_FIRST != 0) ? {sdo_s, cmd_q[7:1]} : {cmd_q[6:0], sdo_s};
    wbuf_nx = (LSB_FIRST != 0) ? {sdo_s, wbuf_q[REGW-1:1]} : {wbuf_q[REGW-2:0], sdo_s};
    stat_w  = REGW'(status_in);
    if (LSB_FIRST == 0) stat_w = stat_w << (REGW - 8);
    idx_ok    = ({28'd0, cmd_q[3:0]} < NREGS);
    idx_ok_nx = ({28'd0, cmd_nx[3:0]} < NREGS);
    rd_sel = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (cmd_nx[3:0] == 4'(i)) rd_sel = rd_in[i*REGW +: REGW];
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q  <= LOCK;
      cnt_q    <= '0;
      cmd_q    <= '0;
      wbuf_q   <= '0;
      obuf_q   <= '0;
      spidi_q  <= 1'b0;
      reg_q    <= '0;
      wr_stb_q <= '0;
      rd_stb_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_stb_q <= '0;
      rd_stb_q <= '0;
      err_q    <= 1'b0;
      if (state_q == LOCK) begin
        // The synchronizer is preset high by reset, so wait until it has
        // refilled from the pin before trusting a high CS.
        if (cnt_q == SYNC_CNT) begin
          if (cs_s) state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 7'd1;
        end
      end else if (cs_rise) begin
        state_q <= IDLE;
        spidi_q <= 1'b0;
        obuf_q  <= '0;
        case (state_q)
          CMD:       err_q <= (cnt_q != 7'd0);
          DATA, OVR: err_q <= 1'b1;
          DONE: begin
            if (!idx_ok) begin
              err_q <= 1'b1;
            end else begin
              for (int unsigned i = 0; i < NREGS; i++) begin
                if (cmd_q[3:0] == 4'(i)) begin
                  if (cmd_q[7]) begin
                    reg_q[i*REGW +: REGW] <= wbuf_q;
                    wr_stb_q[i]           <= 1'b1;
                  end else begin
                    rd_stb_q[i] <= 1'b1;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q <= CMD;
              cnt_q   <= '0;
              spidi_q <= pick(stat_w);
              obuf_q  <= shift(stat_w);
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_q <= cmd_nx;
              if (cnt_q == 7'd7) begin
                state_q <= DATA;
                cnt_q   <= '0;
                obuf_q  <= (!cmd_nx[7] && idx_ok_nx) ? rd_sel : '0;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              wbuf_q <= wbuf_nx;
              if (cnt_q == LAST_DBIT) state_q <= DONE;
              else                    cnt_q   <= cnt_q + 7'd1;
            end
          end
          DONE: if (sck_rise) state_q <= OVR;
          default: ;
        endcase
        if (state_q != IDLE && sck_fall) begin
          spidi_q <= pick(obuf_q);
          obuf_q  <= shift(obuf_q);
        end
      end
    end
  end

  assign spi.spidi = spidi_q & ~cs_s;
  assign reg_out   = reg_q;
  assign wr_stb    = wr_stb_q;
  assign rd_stb    = rd_stb_q;
  assign err       = err_q;

endmodule
